// File: rtl/mci_mcu_rst_req_arb.sv
// Round-robin arbiter for MCU reset requests feeding the MCI boot sequencer.
// Tracks each granted request through sequencer reset entry/exit, with an acknowledge timeout.
module mci_mcu_rst_req_arb #(
  parameter int NUM_REQ       = 3,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     mci_rst_b,
  input  logic [NUM_REQ-1:0]       req_i,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [IDW-1:0]           grant_id_o,
  output logic                     busy_o,
  output logic [NUM_REQ-1:0]       pending_o,
  output logic                     mcu_rst_req_o,
  input  logic                     seq_wait_req_i,
  input  logic                     seq_in_rst_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit_i,
  output logic                     timeout_o,
  output logic [IDW-1:0]           timeout_id_o,
  input  logic                     timeout_clr_i
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_ENTER = 3'd2,
    ST_WAIT_EXIT  = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_REQ-1:0]       r_pending;
  logic [IDW-1:0]           r_rr_ptr;
  logic [IDW-1:0]           r_grant;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_timeout;
  logic [IDW-1:0]           r_timeout_id;

  logic [IDW-1:0]           w_winner;
  logic [IDW:0]             w_idx;
  logic                     w_load_grant;
  logic                     w_clr_cnt;
  logic                     w_inc_cnt;
  logic                     w_to_set;
  logic                     w_retire;
  logic [NUM_REQ-1:0]       w_clr_mask;
  logic [IDW-1:0]           w_next_rr;

  // Winner search: descending scan so the closest index above rr_ptr is the last one kept.
  always_comb begin
    w_winner = r_rr_ptr;
    w_idx    = {(IDW+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx    = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      w_idx    = (w_idx >= NUM_REQ_W) ? (w_idx - NUM_REQ_W) : w_idx;
      w_winner = r_pending[w_idx[IDW-1:0]] ? w_idx[IDW-1:0] : w_winner;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    w_clr_cnt    = 1'b0;
    w_inc_cnt    = 1'b0;
    w_to_set     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|r_pending) && seq_wait_req_i) begin
          w_state_nxt  = ST_ISSUE;
          w_load_grant = 1'b1;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_clr_cnt   = 1'b1;
        w_state_nxt = ST_WAIT_ENTER;
      end
      ST_WAIT_ENTER: begin
        w_inc_cnt = 1'b1;
        // Reset entry beats a coincident timeout.
        if (seq_in_rst_i) begin
          w_state_nxt = ST_WAIT_EXIT;
        end else if ((timeout_limit_i != {TIMEOUT_WIDTH{1'b0}}) && (r_cnt == timeout_limit_i)) begin
          w_to_set    = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_ENTER;
        end
      end
      ST_WAIT_EXIT: begin
        if (!seq_in_rst_i && seq_wait_req_i) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT_EXIT;
        end
      end
      ST_DONE: begin
        w_retire    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Retire mask and round-robin successor of the current grant.
  always_comb begin
    w_clr_mask = w_retire ? (NUM_REQ'(1) << r_grant) : {NUM_REQ{1'b0}};
    w_next_rr  = (r_grant == LAST_ID) ? {IDW{1'b0}} : (r_grant + IDW'(1));
  end

  // State, pending, pointer, counter and timeout registers.
  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      r_state      <= ST_IDLE;
      r_pending    <= {NUM_REQ{1'b0}};
      r_rr_ptr     <= {IDW{1'b0}};
      r_grant      <= {IDW{1'b0}};
      r_cnt        <= {TIMEOUT_WIDTH{1'b0}};
      r_timeout    <= 1'b0;
      r_timeout_id <= {IDW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      // A new request in the retire cycle survives the clear.
      r_pending <= (r_pending & ~w_clr_mask) | req_i;
      r_rr_ptr  <= w_retire ? w_next_rr : r_rr_ptr;
      r_grant   <= w_load_grant ? w_winner : r_grant;
      if (w_clr_cnt) begin
        r_cnt <= {TIMEOUT_WIDTH{1'b0}};
      end else if (w_inc_cnt && (r_cnt != {TIMEOUT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (timeout_clr_i) begin
        r_timeout <= 1'b0;
      end else if (w_to_set) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
      r_timeout_id <= w_to_set ? r_grant : r_timeout_id;
    end
  end

  // Outputs decoded from registered state and grant only.
  always_comb begin
    mcu_rst_req_o = (r_state == ST_ISSUE);
    busy_o        = (r_state != ST_IDLE);
    done_o        = (r_state == ST_DONE) ? (NUM_REQ'(1) << r_grant) : {NUM_REQ{1'b0}};
    grant_id_o    = r_grant;
    pending_o     = r_pending;
    timeout_o     = r_timeout;
    timeout_id_o  = r_timeout_id;
  end

endmodule

// File: tb/tb_mci_mcu_rst_req_arb.sv
// Directed bench for mci_mcu_rst_req_arb: hand-computed expectations checked with immediate assertions.
module tb_mci_mcu_rst_req_arb;

  logic        clk = 1'b0;
  logic        mci_rst_b;
  logic [2:0]  req_i;
  logic [2:0]  done_o;
  logic [1:0]  grant_id_o;
  logic        busy_o;
  logic [2:0]  pending_o;
  logic        mcu_rst_req_o;
  logic        seq_wait_req_i;
  logic        seq_in_rst_i;
  logic [15:0] timeout_limit_i;
  logic        timeout_o;
  logic [1:0]  timeout_id_o;
  logic        timeout_clr_i;

  int checks   = 0;
  int failures = 0;
  logic [2:0] seen_done;
  logic       seen_busy;

  mci_mcu_rst_req_arb #(.NUM_REQ(3), .TIMEOUT_WIDTH(16)) dut (
    .clk             (clk),
    .mci_rst_b       (mci_rst_b),
    .req_i           (req_i),
    .done_o          (done_o),
    .grant_id_o      (grant_id_o),
    .busy_o          (busy_o),
    .pending_o       (pending_o),
    .mcu_rst_req_o   (mcu_rst_req_o),
    .seq_wait_req_i  (seq_wait_req_i),
    .seq_in_rst_i    (seq_in_rst_i),
    .timeout_limit_i (timeout_limit_i),
    .timeout_o       (timeout_o),
    .timeout_id_o    (timeout_id_o),
    .timeout_clr_i   (timeout_clr_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    mci_rst_b       = 1'b0;
    req_i           = 3'b000;
    seq_wait_req_i  = 1'b1;
    seq_in_rst_i    = 1'b0;
    timeout_limit_i = 16'd0;
    timeout_clr_i   = 1'b0;
    tick();
    tick();
    mci_rst_b = 1'b1;
    tick();
  endtask

  // Starts in the expected ISSUE cycle; plays the sequencer and ends in the following IDLE cycle.
  task automatic run_req(input logic [1:0] g, input int hold, input logic [2:0] req_in_done);
    logic [2:0] exp_done;
    logic [2:0] seen;
    exp_done = 3'b001 << g;
    chk("issue_req", mcu_rst_req_o, 1);
    chk("issue_gid", grant_id_o, g);
    chk("issue_busy", busy_o, 1);
    tick();
    chk("enter_req_low", mcu_rst_req_o, 0);
    seq_wait_req_i = 1'b0;
    seq_in_rst_i   = 1'b1;
    seen = 3'b000;
    for (int i = 0; i < hold; i++) begin
      tick();
      seen = seen | done_o | {2'b00, mcu_rst_req_o};
    end
    chk("in_rst_quiet", seen, 0);
    seq_in_rst_i   = 1'b0;
    seq_wait_req_i = 1'b1;
    tick();
    req_i = req_in_done;
    chk("done_pulse", done_o, exp_done);
    tick();
    req_i = 3'b000;
    chk("done_once", done_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_mcu_req", mcu_rst_req_o, 0);
    chk("rst_gid", grant_id_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_tid", timeout_id_o, 0);

    // Single request from requester 1
    req_i = 3'b010;
    tick();
    req_i = 3'b000;
    chk("single_pend", pending_o, 3'b010);
    chk("single_c1_req", mcu_rst_req_o, 0);
    tick();
    run_req(2'd1, 10, 3'b000);
    chk("single_pend_clr", pending_o, 0);

    // Round-robin 0,1,2 from reset
    do_reset();
    req_i = 3'b111;
    tick();
    req_i = 3'b000;
    tick();
    run_req(2'd0, 3, 3'b000);
    chk("rr_pend_a", pending_o, 3'b110);
    tick();
    run_req(2'd1, 3, 3'b000);
    chk("rr_pend_b", pending_o, 3'b100);
    tick();
    run_req(2'd2, 3, 3'b000);
    chk("rr_pend_c", pending_o, 0);

    // 3'b101 from reset: grants 0 then 2
    do_reset();
    req_i = 3'b101;
    tick();
    req_i = 3'b000;
    tick();
    run_req(2'd0, 2, 3'b000);
    tick();
    run_req(2'd2, 2, 3'b000);
    chk("rr101_pend", pending_o, 0);

    // Re-request of grant 0 in its DONE cycle is kept and served after 1
    do_reset();
    req_i = 3'b011;
    tick();
    req_i = 3'b000;
    tick();
    run_req(2'd0, 2, 3'b001);
    chk("setclr_pend", pending_o, 3'b011);
    tick();
    run_req(2'd1, 2, 3'b000);
    tick();
    run_req(2'd0, 2, 3'b000);
    chk("setclr_pend_end", pending_o, 0);

    // Timeout with limit 5 on requester 2
    do_reset();
    timeout_limit_i = 16'd5;
    req_i = 3'b100;
    tick();
    req_i = 3'b000;
    tick();
    chk("to_issue", mcu_rst_req_o, 1);
    tick();
    seen_done = 3'b000;
    for (int i = 0; i < 5; i++) begin
      seen_done = seen_done | done_o;
      tick();
    end
    chk("to_wait5_busy", busy_o, 1);
    chk("to_wait5_flag", timeout_o, 0);
    seen_done = seen_done | done_o;
    tick();
    chk("to_flag", timeout_o, 1);
    chk("to_id", timeout_id_o, 2'd2);
    chk("to_pend", pending_o, 0);
    chk("to_busy", busy_o, 0);
    seen_done = seen_done | done_o;
    chk("to_no_done", seen_done, 0);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    chk("to_cleared", timeout_o, 0);
    chk("to_id_hold", timeout_id_o, 2'd2);

    // Limit 0: wait forever in WAIT_ENTER, then reset during WAIT_EXIT
    timeout_limit_i = 16'd0;
    req_i = 3'b001;
    tick();
    req_i = 3'b000;
    tick();
    chk("nolim_issue", mcu_rst_req_o, 1);
    chk("nolim_gid", grant_id_o, 2'd0);
    tick();
    repeat (40) tick();
    chk("nolim_busy", busy_o, 1);
    chk("nolim_flag", timeout_o, 0);
    seq_wait_req_i = 1'b0;
    seq_in_rst_i   = 1'b1;
    tick();
    tick();
    req_i = 3'b010;
    tick();
    req_i = 3'b000;
    chk("mid_pend", pending_o, 3'b011);
    chk("mid_busy", busy_o, 1);
    mci_rst_b = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_pend", pending_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_tid", timeout_id_o, 0);
    chk("arst_gid", grant_id_o, 0);
    tick();
    mci_rst_b      = 1'b1;
    seq_in_rst_i   = 1'b0;
    seq_wait_req_i = 1'b1;
    seen_done = 3'b000;
    seen_busy = 1'b0;
    repeat (6) begin
      tick();
      seen_done = seen_done | done_o;
      seen_busy = seen_busy | busy_o;
    end
    chk("post_rst_done", seen_done, 0);
    chk("post_rst_busy", seen_busy, 0);

    // Gated by sequencer not waiting
    do_reset();
    seq_wait_req_i = 1'b0;
    req_i = 3'b001;
    tick();
    req_i = 3'b000;
    seen_busy = 1'b0;
    repeat (4) begin
      tick();
      seen_busy = seen_busy | busy_o | mcu_rst_req_o;
    end
    chk("gate_quiet", seen_busy, 0);
    chk("gate_pend", pending_o, 3'b001);
    seq_wait_req_i = 1'b1;
    tick();
    run_req(2'd0, 2, 3'b000);
    chk("gate_pend_clr", pending_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
